// File: rtl/glyph_serializer.sv
// Glyph row serializer: fetches one 8-pixel scanline from a glyph ROM
// (or synthesizes a blank one) and streams it MSB first over valid/ready.
module glyph_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_char,
    input  logic [2:0] req_row,
    input  logic       req_blank,
    input  logic       req_invert,
    output logic       rom_enable,
    output logic [9:0] rom_address,
    input  logic [7:0] rom_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_bit,
    output logic       pix_last
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shifter;
    logic [2:0] count;
    logic       invert;
    logic       accept;
    logic       xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rom_enable = 1'b0;
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_blank ? SHIFT : FETCH;
                end
            end
            FETCH: begin
                rom_enable = 1'b1;
                state_nxt  = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                pix_valid = 1'b1;
                pix_last  = (count == 3'd7);
                if (pix_ready && pix_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Reset is synchronous, so mask outputs until the state register clears
        if (rst) begin
            req_ready  = 1'b0;
            rom_enable = 1'b0;
            pix_valid  = 1'b0;
            pix_last   = 1'b0;
        end
    end

    assign pix_bit = pix_valid & shifter[7];
    assign accept  = req_valid & req_ready;
    assign xfer    = pix_valid & pix_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter     <= 8'h00;
            count       <= 3'd0;
            invert      <= 1'b0;
            rom_address <= 10'd0;
        end else begin
            if (accept) begin
                if (req_blank) begin
                    shifter <= {8{req_invert}};
                    count   <= 3'd0;
                end else begin
                    rom_address <= {req_char, req_row};
                    invert      <= req_invert;
                end
            end
            if (state == CAPTURE) begin
                shifter <= rom_data ^ {8{invert}};
                count   <= 3'd0;
            end
            if (xfer) begin
                shifter <= {shifter[6:0], 1'b0};
                count   <= count + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_glyph_serializer.sv
// Testbench for glyph_serializer: directed scenarios plus random rows
// checked against a row-level model of ROM lookup, inversion and timing.
module tb_glyph_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_char;
    logic [2:0] req_row;
    logic       req_blank;
    logic       req_invert;
    logic       rom_enable;
    logic [9:0] rom_address;
    logic [7:0] rom_data = 8'h00;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_bit;
    logic       pix_last;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [9:0] mdl_addr;

    always #5 clk = ~clk;

    glyph_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_char   (req_char),
        .req_row    (req_row),
        .req_blank  (req_blank),
        .req_invert (req_invert),
        .rom_enable (rom_enable),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_bit    (pix_bit),
        .pix_last   (pix_last)
    );

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        if (a == 10'h0A3) return 8'hA5;
        return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h3C;
    endfunction

    // Registered ROM: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (rom_enable) rom_data <= rom_fn(rom_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rom_en"}, 32'(rom_enable), 32'(1'b0));
        chk({tag, "_pvalid"}, 32'(pix_valid), 32'(1'b0));
        chk({tag, "_pbit"}, 32'(pix_bit), 32'(1'b0));
        chk({tag, "_plast"}, 32'(pix_last), 32'(1'b0));
    endtask

    task automatic do_req(input logic [6:0] ch, input logic [2:0] rw,
                          input logic bl, input logic iv,
                          input int stall_at, input int stall_len,
                          input bit hold_valid);
        logic [7:0] exp;
        int idx;
        int ens;
        int first;
        int stall_left;
        logic xf;
        exp = (bl ? 8'h00 : rom_fn({ch, rw})) ^ {8{iv}};
        req_char   = ch;
        req_row    = rw;
        req_blank  = bl;
        req_invert = iv;
        req_valid  = 1'b1;
        pix_ready  = 1'b1;
        chk("ready_idle", 32'(req_ready), 32'(1'b1));
        step();
        if (!bl) mdl_addr = {ch, rw};
        if (!hold_valid) req_valid = 1'b0;
        idx = 0;
        ens = 0;
        first = -1;
        stall_left = stall_len;
        for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
            chk("ready_busy", 32'(req_ready), 32'(1'b0));
            chk("rom_addr", 32'(rom_address), 32'(mdl_addr));
            if (rom_enable) ens++;
            if (pix_valid) begin
                if (first < 0) first = cyc;
                chk("pix_bit", 32'(pix_bit), 32'(exp[7-idx]));
                chk("pix_last", 32'(pix_last), 32'(idx == 7));
            end
            if (pix_valid && idx == stall_at && stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else begin
                pix_ready = 1'b1;
            end
            if (hold_valid) begin
                req_char   = 7'($urandom);
                req_row    = 3'($urandom);
                req_blank  = 1'($urandom);
                req_invert = 1'($urandom);
            end
            xf = pix_valid & pix_ready;
            step();
            if (xf) idx++;
        end
        chk("pix_count", 32'(idx), 32'd8);
        chk("rom_pulses", 32'(ens), bl ? 32'd0 : 32'd1);
        chk("latency", 32'(first), bl ? 32'd0 : 32'd2);
        chk("ready_after", 32'(req_ready), 32'(1'b1));
        chk("valid_after", 32'(pix_valid), 32'(1'b0));
        req_valid = 1'b0;
        pix_ready = 1'b1;
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_char   = 7'd0;
        req_row    = 3'd0;
        req_blank  = 1'b0;
        req_invert = 1'b0;
        pix_ready  = 1'b1;
        mdl_addr   = 10'd0;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'(1'b0));
        chk("rst_addr", 32'(rom_address), 32'd0);
        chk_quiet("rst");
        rst = 1'b0;
        #1;
        chk("ready_release", 32'(req_ready), 32'(1'b1));

        do_req(7'h14, 3'd3, 1'b0, 1'b0, -1, 0, 1'b0);
        do_req(7'h14, 3'd3, 1'b0, 1'b1, -1, 0, 1'b0);
        do_req(7'h55, 3'd5, 1'b1, 1'b1, -1, 0, 1'b0);
        do_req(7'h14, 3'd3, 1'b0, 1'b0, 3, 5, 1'b0);
        do_req(7'h22, 3'd1, 1'b0, 1'b0, -1, 0, 1'b1);
        do_req(7'h0F, 3'd6, 1'b1, 1'b0, 2, 2, 1'b1);

        // reset while in CAPTURE
        req_char   = 7'h14;
        req_row    = 3'd3;
        req_blank  = 1'b0;
        req_invert = 1'b0;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        mdl_addr = 10'd0;
        chk("rstc_ready", 32'(req_ready), 32'(1'b0));
        chk("rstc_addr", 32'(rom_address), 32'd0);
        chk_quiet("rstc");
        rst = 1'b0;
        #1;
        chk("rstc_release", 32'(req_ready), 32'(1'b1));
        repeat (2) begin
            step();
            chk_quiet("rstc_post");
        end

        // reset in SHIFT after four pixels
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (pix_valid) k++;
            step();
        end
        chk("rsts_reach", 32'(k), 32'd4);
        rst = 1'b1;
        step();
        chk("rsts_ready", 32'(req_ready), 32'(1'b0));
        chk_quiet("rsts");
        rst = 1'b0;
        #1;
        chk("rsts_release", 32'(req_ready), 32'(1'b1));
        step();
        chk_quiet("rsts_post");
        do_req(7'h14, 3'd3, 1'b0, 1'b0, -1, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_req(7'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), $urandom_range(0, 7),
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_serializer.md
GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: a glyph-row request is offered.
REQ-004 SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-005 SHALL have port req_char, input, 7 bits: character code, 0-127.
REQ-006 SHALL have port req_row, input, 3 bits: glyph scanline, 0-7.
REQ-007 SHALL have port req_blank, input, 1 bit: emit 8 background pixels without a ROM access.
REQ-008 SHALL have port req_invert, input, 1 bit: invert all 8 pixels of this row.
REQ-009 SHALL have port rom_enable, output, 1 bit: read strobe to the glyph ROM.
REQ-010 SHALL have port rom_address, output, 10 bits: glyph ROM word address.
REQ-011 SHALL have port rom_data, input, 8 bits: glyph ROM registered output, valid one cycle after the strobe.
REQ-012 SHALL have port pix_valid, output, 1 bit: pix_bit is valid.
REQ-013 SHALL have port pix_ready, input, 1 bit: the downstream consumer accepts the pixel.
REQ-014 SHALL have port pix_bit, output, 1 bit: pixel value, 1 = foreground.
REQ-015 SHALL have port pix_last, output, 1 bit: marks the eighth pixel of the glyph row.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, FETCH, CAPTURE, SHIFT.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-018 SHALL, on an accepted request with req_blank=0, register rom_address={req_char,req_row} and the invert flag, then go to FETCH.
REQ-019 SHALL, on an accepted request with req_blank=1, load the shifter with 8'h00 XOR {8{req_invert}}, go directly to SHIFT, and leave rom_enable and rom_address unchanged.
REQ-020 SHALL assert rom_enable=1 for exactly one cycle, in FETCH, then go to CAPTURE unconditionally.
REQ-021 SHALL, in CAPTURE, load the shifter with rom_data XOR {8{invert}}, clear the 3-bit pixel counter, and go to SHIFT.
REQ-022 SHALL keep rom_enable=0 in all states other than FETCH.
REQ-023 SHALL hold rom_address at its last value while outside FETCH.
REQ-024 SHALL, in SHIFT, drive pix_valid=1 and pix_bit=shifter[7], so pixels leave MSB first (bit 7 is the leftmost pixel).
REQ-025 SHALL, on each pix_valid and pix_ready transfer, shift the shifter left by one and increment the counter.
REQ-026 SHALL, while pix_ready=0, hold pix_bit, pix_last and the counter stable.
REQ-027 SHALL drive pix_last=1 when the counter equals 7 in SHIFT.
REQ-028 SHALL, on the transfer where pix_last=1, wrap the counter to 0 and return to IDLE.
REQ-029 SHALL drive pix_valid=0 and pix_last=0 outside SHIFT.
REQ-030 SHALL have a latency of 3 cycles for a non-blank request: accept at edge N, FETCH in cycle N+1, CAPTURE in cycle N+2, first pix_valid in cycle N+3.
REQ-031 SHALL have a latency of 1 cycle for a blank request: first pix_valid in cycle N+1.
REQ-032 SHALL deliver back-to-back requests with at most 1 idle cycle between glyph rows for blank requests and 3 for non-blank requests.
REQ-033 SHALL ignore req_valid and all request fields outside IDLE.
REQ-034 SHALL not register request fields unless a request is accepted.

Reset
REQ-035 SHALL, while rst=1, force the state to IDLE and set the shifter, counter, invert flag and rom_address to 0.
REQ-036 SHALL, while rst=1, drive rom_enable, pix_valid, pix_bit and pix_last to 0.
REQ-037 SHALL drive req_ready=0 while rst=1, and req_ready=1 from the first cycle after rst falls.
REQ-038 SHALL, on reset in any state, abandon the row in progress without emitting further pixels and without a further rom_enable.

Verification
REQ-039 SHALL be verified by a bench whose ROM model returns 8'hA5 at address 10'h0A3.
REQ-040 SHALL be verified by a bench scenario: char=7'h14, row=3, blank=0, invert=0, pix_ready=1 -> exactly one rom_enable pulse at 10'h0A3, then pix_bit 1,0,1,0,0,1,0,1 in cycles N+3 to N+10, with pix_last only in cycle N+10.
REQ-041 SHALL be verified by a bench scenario: the same request with invert=1 -> pix_bit 0,1,0,1,1,0,1,0.
REQ-042 SHALL be verified by a bench scenario: blank=1, invert=1 -> no rom_enable, rom_address unchanged, eight 1s starting in cycle N+1.
REQ-043 SHALL be verified by a bench scenario: pix_ready=0 for 5 cycles after the third pixel -> pix_bit and pix_last held, then the sequence resumes with all 8 pixels delivered exactly once.
REQ-044 SHALL be verified by a bench scenario: rst=1 in CAPTURE and then in SHIFT after pixel 4 -> all outputs 0 on the next cycle, req_ready=1 after release, and a new request produces a full correct row.
REQ-045 SHALL be verified by a bench scenario: req_valid held high with changing fields during SHIFT -> fields ignored, with the next accept only in IDLE.
